// File: rtl/mult_div_unit_pkg.sv
// mdu_pkg: funct codes, FSM state encoding and iteration count for the multiply/divide unit.
package mdu_pkg;
  localparam int ITER_DEFAULT = 32;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  // MULT/MULTU/DIV/DIVU share the 0110xx prefix; bit1 selects divide, bit0 unsigned
  function automatic logic is_muldiv(input logic [5:0] c);
    return c[5:2] == 4'b0110;
  endfunction
endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: execute-stage control/operand bus between core and multiply/divide unit.
interface mult_div_unit_if;
  logic [31:0] i_op1;
  logic [31:0] i_op2;
  logic [5:0]  i_control;
  logic        i_start;
  logic [31:0] o_result;
  logic [31:0] o_hi;
  logic [31:0] o_lo;
  logic        o_busy;
  logic        o_done;
  modport master (output i_op1, i_op2, i_control, i_start, input o_result, o_hi, o_lo, o_busy, o_done);
  modport slave  (input i_op1, i_op2, i_control, i_start, output o_result, o_hi, o_lo, o_busy, o_done);
endinterface

// File: rtl/mult_div_unit_div_step.sv
// mdu_div_step: one restoring-divide iteration on {remainder, next dividend bit}.
module mdu_div_step (
  input  logic [31:0] rem,
  input  logic        dbit,
  input  logic [31:0] divisor,
  output logic [31:0] new_rem,
  output logic        q
);
  logic [32:0] trial;
  assign trial = {rem, dbit};
  assign q = trial >= {1'b0, divisor};
  assign new_rem = q ? 32'(trial - {1'b0, divisor}) : trial[31:0];
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle MULT/MULTU/DIV/DIVU owning HI/LO, plus MFHI/MFLO/MTHI/MTLO.
// Define MDU_FAST_MULT_EN to compute multiplies in a single CALC cycle.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int ITER = ITER_DEFAULT
) (
  input logic i_clk,
  input logic i_rst,
  mult_div_unit_if.slave bus
);
  localparam int CW = $clog2(ITER + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [31:0] hi, lo, mcand, raw1, mag1, mag2, new_rem, q_fix, r_fix;
  logic [63:0] prod, fixed;
  logic [32:0] acc;
  logic is_div, neg_q, neg_r, dz, busy, done, sgn1, sgn2, q_bit, go;
  assign go = bus.i_start && is_muldiv(bus.i_control);
  assign sgn1 = ~bus.i_control[0] & bus.i_op1[31];
  assign sgn2 = ~bus.i_control[0] & bus.i_op2[31];
  assign mag1 = sgn1 ? -bus.i_op1 : bus.i_op1;
  assign mag2 = sgn2 ? -bus.i_op2 : bus.i_op2;
  // prod doubles as {partial product, multiplier} or {remainder, dividend/quotient}
  assign acc = prod[0] ? {1'b0, prod[63:32]} + {1'b0, mcand} : {1'b0, prod[63:32]};
  assign fixed = neg_q ? -prod : prod;
  assign q_fix = neg_q ? -prod[31:0] : prod[31:0];
  assign r_fix = neg_r ? -prod[63:32] : prod[63:32];
  mdu_div_step u_step (
    .rem(prod[63:32]),
    .dbit(prod[31]),
    .divisor(mcand),
    .new_rem(new_rem),
    .q(q_bit)
  );
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state <= IDLE;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      mcand <= '0;
      raw1 <= '0;
      prod <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE:
          if (go) begin
            state <= CALC;
            busy <= 1'b1;
            cnt <= '0;
            is_div <= bus.i_control[1];
            neg_q <= sgn1 ^ sgn2;
            neg_r <= sgn1;
            dz <= bus.i_control[1] && bus.i_op2 == '0;
            raw1 <= bus.i_op1;
            mcand <= bus.i_control[1] ? mag2 : mag1;
            prod <= {32'd0, bus.i_control[1] ? mag1 : mag2};
          end else if (bus.i_start && bus.i_control == F_MTHI)
            hi <= bus.i_op1;
          else if (bus.i_start && bus.i_control == F_MTLO)
            lo <= bus.i_op1;
        CALC: begin
          cnt <= cnt + CW'(1);
          prod <= is_div ? {new_rem, prod[30:0], q_bit} : {acc, prod[31:1]};
          if (cnt == CW'(ITER - 1)) state <= FIX;
`ifdef MDU_FAST_MULT_EN
          if (!is_div) begin
            prod <= {32'd0, mcand} * {32'd0, prod[31:0]};
            state <= FIX;
          end
`endif
        end
        FIX: begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
          // divide by zero leaves the dividend in HI untouched by sign correction
          {hi, lo} <= !is_div ? fixed : dz ? {raw1, 32'hFFFF_FFFF} : {r_fix, q_fix};
        end
        default: state <= IDLE;
      endcase
    end
  assign bus.o_result = bus.i_control == F_MFHI ? hi : bus.i_control == F_MFLO ? lo : 32'd0;
  assign bus.o_hi = hi;
  assign bus.o_lo = lo;
  assign bus.o_busy = busy;
  assign bus.o_done = done;
endmodule
